// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the dual-clock FIFO: Gray/binary conversion and
// default sizing, used by the write side, the read side and the synchroniser.
package fifo_pkg;

   localparam int FIFO_PTR_WIDTH = 4;

   // Both helpers work on zero-extended values, so they suit any width up to 32.
   function automatic logic [31:0] bin2gray(input logic [31:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] gray);
      logic [31:0] bin;
      bin = '0;
      for (int i = 0; i < 32; i++) begin
         bin[i] = ^(gray >> i);
      end
      return bin;
   endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above it.
module fifo_gray2bin #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // NOTE: every bit is assigned on every pass through the loop, so no latch is inferred.
   always_comb begin
      bin = '0;
      for (int i = 0; i < WIDTH; i++) begin
         bin[i] = ^(gray >> i);
      end
   end

endmodule

// File: rtl/fifo_wr.sv
// Write-side control of the async FIFO: binary/Gray write pointer, memory
// write strobe, and full / almost-full / overflow / level status in wclk.
module fifo_wr
   import fifo_pkg::*;
#(
   parameter int PTR_WIDTH    = FIFO_PTR_WIDTH,
   parameter int AFULL_THRESH = 6
) (
   input  logic                 wclk,
   input  logic                 wrst_n,
   input  logic                 winc,
   input  logic                 wovf_clr,
   input  logic [PTR_WIDTH-1:0] synced_rd_ptr,
   output logic [PTR_WIDTH-1:0] wptr_grey,
   output logic [PTR_WIDTH-2:0] waddr,
   output logic                 wclken,
   output logic                 wfull,
   output logic                 walmost_full,
   output logic                 woverflow,
   output logic [PTR_WIDTH-1:0] wlevel
);

   localparam logic [PTR_WIDTH-1:0] AFULL_LVL = PTR_WIDTH'(AFULL_THRESH);

   logic [PTR_WIDTH-1:0] wptr_bin;
   logic [PTR_WIDTH-1:0] wptr_bin_nxt;
   logic [PTR_WIDTH-1:0] rd_bin;
   logic [PTR_WIDTH-1:0] full_match;

   fifo_gray2bin #(.WIDTH(PTR_WIDTH)) u_rd_g2b (
      .gray (synced_rd_ptr),
      .bin  (rd_bin)
   );

   // Full when the write pointer has lapped the read pointer: top two Gray bits
   // inverted, the rest equal.
   assign full_match   = {~synced_rd_ptr[PTR_WIDTH-1:PTR_WIDTH-2], synced_rd_ptr[PTR_WIDTH-3:0]};
   assign wfull        = (wptr_grey == full_match);
   assign wclken       = winc & ~wfull;
   assign waddr        = wptr_bin[PTR_WIDTH-2:0];
   assign wptr_bin_nxt = wptr_bin + PTR_WIDTH'(1);
   assign wlevel       = wptr_bin - rd_bin;
   assign walmost_full = (wlevel >= AFULL_LVL);

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wptr_bin  <= '0;
         wptr_grey <= '0;
         woverflow <= 1'b0;
      end else begin
         if (wclken) begin
            wptr_bin  <= wptr_bin_nxt;
            // Registered straight from the next binary value so the crossing bus is glitch-free.
            wptr_grey <= PTR_WIDTH'(bin2gray(32'(wptr_bin_nxt)));
         end
         if (winc && wfull) begin
            woverflow <= 1'b1;
         end else if (wovf_clr) begin
            woverflow <= 1'b0;
         end
      end
   end

endmodule
